// File: rtl/operand_fetch.sv
// Operand fetch stage: register-bank read with writeback bypass, per-register busy scoreboard,
// one-entry output slot and hazard stall counter. Optional macro REG0_ZERO_EN hardwires register 0 to zero.
`timescale 1ns/1ps
module operand_fetch #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_rs1,
    input  logic [ADDR_SIZE-1:0] in_rs2,
    input  logic [ADDR_SIZE-1:0] in_rd,
    input  logic                 in_rd_en,
    output logic [ADDR_SIZE-1:0] rf_rad1,
    output logic [ADDR_SIZE-1:0] rf_rad2,
    input  logic [WORD_SIZE-1:0] rf_rdat1,
    input  logic [WORD_SIZE-1:0] rf_rdat2,
    input  logic                 wb_w,
    input  logic [ADDR_SIZE-1:0] wb_wad,
    input  logic [WORD_SIZE-1:0] wb_wdat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_op1,
    output logic [WORD_SIZE-1:0] out_op2,
    output logic [ADDR_SIZE-1:0] out_rd,
    output logic                 out_rd_en,
    output logic [15:0]          stall_cnt
);

    localparam int NREG = 1 << ADDR_SIZE;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t                 state_q, state_d;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       set_mask;
    logic [NREG-1:0]       clr_mask;
    logic [15:0]           stall_cnt_q;
    logic [WORD_SIZE-1:0]  op1_p1, op2_p1;
    logic [ADDR_SIZE-1:0]  rd_p1;
    logic                  rd_en_p1;

    logic                  rs1_zero, rs2_zero, rd_zero;
    logic                  rs1_wb_hit, rs2_wb_hit;
    logic                  rs1_busy, rs2_busy, rd_busy;
    logic                  hazard, accept;
    logic [WORD_SIZE-1:0]  op1_p0, op2_p0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef REG0_ZERO_EN
    assign rs1_zero = (in_rs1 == '0);
    assign rs2_zero = (in_rs2 == '0);
    assign rd_zero  = (in_rd  == '0);
`else
    assign rs1_zero = 1'b0;
    assign rs2_zero = 1'b0;
    assign rd_zero  = 1'b0;
`endif

    // ---- stage p0: read, bypass, hazard detection ----
    assign rf_rad1 = in_rs1;
    assign rf_rad2 = in_rs2;

    assign rs1_wb_hit = wb_w && (wb_wad == in_rs1);
    assign rs2_wb_hit = wb_w && (wb_wad == in_rs2);

    // A bit being cleared by this cycle's writeback no longer blocks issue.
    assign rs1_busy = !rs1_zero && busy_q[in_rs1] && !rs1_wb_hit;
    assign rs2_busy = !rs2_zero && busy_q[in_rs2] && !rs2_wb_hit;
    assign rd_busy  = !rd_zero  && busy_q[in_rd]  && !(wb_w && (wb_wad == in_rd));

    assign hazard   = rs1_busy || rs2_busy || (in_rd_en && rd_busy);
    assign in_ready = !reset && !hazard && ((state_q == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    assign op1_p0 = rs1_zero ? '0 : (rs1_wb_hit ? wb_wdat : rf_rdat1);
    assign op2_p0 = rs2_zero ? '0 : (rs2_wb_hit ? wb_wdat : rf_rdat2);

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_w)
            clr_mask[wb_wad] = 1'b1;
        if (accept && in_rd_en && !rd_zero)
            set_mask[in_rd] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == EMPTY) begin
            if (accept)
                state_d = FULL;
        end else begin
            if (out_ready && !accept)
                state_d = EMPTY;
        end
    end

    // ---- stage p1: output slot, scoreboard, counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // Set is applied after clear so a same-cycle set on the written address wins.
            busy_q  <= (busy_q & ~clr_mask) | set_mask;
            if (in_valid && hazard)
                stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op1_p1   <= '0;
            op2_p1   <= '0;
            rd_p1    <= '0;
            rd_en_p1 <= 1'b0;
        end else if (accept) begin
            op1_p1   <= op1_p0;
            op2_p1   <= op2_p0;
            rd_p1    <= in_rd;
            rd_en_p1 <= in_rd_en;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_op1   = op1_p1;
    assign out_op2   = op2_p1;
    assign out_rd    = rd_p1;
    assign out_rd_en = rd_en_p1;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic against a scoreboard model.
`timescale 1ns/1ps
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_rd_en;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_rad1, rf_rad2, wb_wad, out_rd;
    logic [31:0] rf_rdat1, rf_rdat2, wb_wdat, out_op1, out_op2;
    logic        wb_w, out_valid, out_ready, out_rd_en;
    logic [15:0] stall_cnt;

    int checks = 0;
    int passes = 0;

    // reference model state
    bit          m_busy [32];
    bit          m_full;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    bit          m_rd_en;
    int          m_cnt;

    operand_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .rf_rad1(rf_rad1), .rf_rad2(rf_rad2), .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
        .wb_w(wb_w), .wb_wad(wb_wad), .wb_wdat(wb_wdat),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_en(out_rd_en), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

`ifdef REG0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    function automatic bit m_isbusy(input int a);
        if (R0Z && a == 0) return 1'b0;
        return m_busy[a] && !(wb_w && int'(wb_wad) == a);
    endfunction

    function automatic bit m_hazard();
        return m_isbusy(int'(in_rs1)) || m_isbusy(int'(in_rs2)) || (in_rd_en && m_isbusy(int'(in_rd)));
    endfunction

    function automatic bit m_ready();
        return !reset && !m_hazard() && (!m_full || out_ready);
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] rs, input logic [31:0] bank);
        if (R0Z && rs == 0) return 32'h0;
        if (wb_w && wb_wad == rs) return wb_wdat;
        return bank;
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        bit hz, acc;
        hz  = m_hazard();
        acc = in_valid && m_ready();
        @(posedge clk);
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_full = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_en = 0; m_cnt = 0;
        end else begin
            if (in_valid && hz && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (acc) begin
                m_full  = 1;
                m_op1   = m_operand(in_rs1, rf_rdat1);
                m_op2   = m_operand(in_rs2, rf_rdat2);
                m_rd    = in_rd;
                m_rd_en = in_rd_en;
            end else if (out_ready) begin
                m_full = 0;
            end
            if (wb_w) m_busy[wb_wad] = 1'b0;
            if (acc && in_rd_en && !(R0Z && in_rd == 0)) m_busy[in_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_en = 0;
        rf_rdat1 = 0; rf_rdat2 = 0; wb_w = 0; wb_wad = 0; wb_wdat = 0; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else passes++;
        tick(); tick();
        reset = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passes++;
        checks++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall_cnt: got %0h want 0", stall_cnt); else passes++;
        checks++; if (out_op1 !== 32'h0 || out_op2 !== 32'h0) $display("FAIL reset_ops: got %0h/%0h want 0/0", out_op1, out_op2); else passes++;
        checks++; if (out_rd !== 5'd0 || out_rd_en !== 1'b0) $display("FAIL reset_rd: got %0d/%0b want 0/0", out_rd, out_rd_en); else passes++;
    endtask

    task automatic test_basic();
        in_valid = 1; in_rs1 = 3; in_rs2 = 4; rf_rdat1 = 32'h11; rf_rdat2 = 32'h22;
        in_rd = 5; in_rd_en = 1; out_ready = 0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %0b want 1", in_ready); else passes++;
        checks++; if (rf_rad1 !== 5'd3 || rf_rad2 !== 5'd4) $display("FAIL basic_rad: got %0d/%0d want 3/4", rf_rad1, rf_rad2); else passes++;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %0b want 1", out_valid); else passes++;
        checks++; if (out_op1 !== 32'h11 || out_op2 !== 32'h22) $display("FAIL basic_ops: got %0h/%0h want 11/22", out_op1, out_op2); else passes++;
        checks++; if (out_rd !== 5'd5 || out_rd_en !== 1'b1) $display("FAIL basic_rd: got %0d/%0b want 5/1", out_rd, out_rd_en); else passes++;
        out_ready = 1; in_valid = 1; in_rs1 = 5; in_rs2 = 0; in_rd_en = 0;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL basic_busy5: in_ready got %0b want 0", in_ready); else passes++;
    endtask

    task automatic test_hazard_bypass();
        repeat (3) tick();
        checks++; if (stall_cnt !== 16'd3) $display("FAIL hazard_stall_cnt: got %0d want 3", stall_cnt); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL hazard_drained: got %0b want 0", out_valid); else passes++;
        wb_w = 1; wb_wad = 5; wb_wdat = 32'hABCD; rf_rdat1 = 32'h99;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL hazard_release: in_ready got %0b want 1", in_ready); else passes++;
        tick();
        wb_w = 0; in_valid = 0;
        checks++; if (out_op1 !== 32'hABCD) $display("FAIL hazard_bypass_op1: got %0h want abcd", out_op1); else passes++;
        checks++; if (out_valid !== 1'b1 || stall_cnt !== 16'd3) $display("FAIL hazard_after: valid %0b cnt %0d want 1/3", out_valid, stall_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd_en = 0; rf_rdat1 = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); else passes++;
            tick();
            checks++; if (out_valid !== 1'b1 || out_op1 !== 32'hABCD) $display("FAIL bp_hold[%0d]: valid %0b op1 %0h want 1/abcd", i, out_valid, out_op1); else passes++;
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            rf_rdat1 = 32'h100 + i;
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, in_ready); else passes++;
            tick();
            checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h100 + i) $display("FAIL b2b_pkt[%0d]: valid %0b op1 %0h want 1/%0h", i, out_valid, out_op1, 32'h100 + i); else passes++;
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", out_valid); else passes++;
    endtask

    task automatic test_set_clear_same_cycle();
        in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 7; in_rd_en = 1;
        wb_w = 1; wb_wad = 7; wb_wdat = 32'h0;
        #1;
        tick();
        wb_w = 0; in_rd_en = 0; in_rs1 = 7;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL setclr_busy7: in_ready got %0b want 0", in_ready); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_reg0();
        reset = 1; tick(); reset = 0;
        in_valid = 1; in_rs1 = 0; in_rs2 = 1; in_rd = 0; in_rd_en = 1; out_ready = 1;
        wb_w = 1; wb_wad = 0; wb_wdat = 32'h5; rf_rdat1 = 32'h77; rf_rdat2 = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reg0_accept: in_ready got %0b want 1", in_ready); else passes++;
        tick();
        wb_w = 0; in_rd_en = 0;
        #1;
        checks++; if (out_op1 !== (R0Z ? 32'h0 : 32'h5)) $display("FAIL reg0_op1: got %0h want %0h", out_op1, R0Z ? 32'h0 : 32'h5); else passes++;
        checks++; if (in_ready !== R0Z) $display("FAIL reg0_busy: in_ready got %0b want %0b", in_ready, R0Z); else passes++;
        in_valid = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 9; in_rd_en = 1;
        #1;
        tick();
        in_rs1 = 9; in_rd_en = 0;
        tick(); tick();
        checks++; if (stall_cnt !== 16'd2 || out_valid !== 1'b1) $display("FAIL rstmid_pre: cnt %0d valid %0b want 2/1", stall_cnt, out_valid); else passes++;
        reset = 1; wb_w = 1; wb_wad = 3;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %0b want 0", in_ready); else passes++;
        tick();
        reset = 0; in_valid = 0; wb_w = 0;
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) $display("FAIL rstmid_state: valid %0b cnt %0d want 0/0", out_valid, stall_cnt); else passes++;
        checks++; if (out_op1 !== 32'h0 || out_rd !== 5'd0 || out_rd_en !== 1'b0) $display("FAIL rstmid_pkt: op1 %0h rd %0d en %0b want 0", out_op1, out_rd, out_rd_en); else passes++;
        in_valid = 1; in_rs1 = 9; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_busy_clear: in_ready got %0b want 1", in_ready); else passes++;
        in_valid = 0;
    endtask

    task automatic test_random();
        int errs = 0;
        reset = 1; #1; tick(); reset = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_rs1    = 5'($urandom % 8);
            in_rs2    = 5'($urandom % 8);
            in_rd     = 5'($urandom % 8);
            in_rd_en  = 1'($urandom % 2);
            rf_rdat1  = $urandom;
            rf_rdat2  = $urandom;
            wb_w      = ($urandom % 3) == 0;
            wb_wad    = 5'($urandom % 8);
            wb_wdat   = $urandom;
            out_ready = ($urandom % 4) != 0;
            reset     = ($urandom % 64) == 0;
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errs++; $display("FAIL rnd_in_ready[%0d]: got %0b want %0b", n, in_ready, m_ready());
            end else passes++;
            tick();
            checks++;
            if (out_valid !== m_full || stall_cnt !== 16'(m_cnt)) begin
                errs++; $display("FAIL rnd_state[%0d]: valid %0b cnt %0d want %0b/%0d", n, out_valid, stall_cnt, m_full, m_cnt);
            end else passes++;
            if (m_full) begin
                checks++;
                if (out_op1 !== m_op1 || out_op2 !== m_op2 || out_rd !== m_rd || out_rd_en !== m_rd_en) begin
                    errs++; $display("FAIL rnd_pkt[%0d]: got %0h/%0h/%0d/%0b want %0h/%0h/%0d/%0b", n, out_op1, out_op2, out_rd, out_rd_en, m_op1, m_op2, m_rd, m_rd_en);
                end else passes++;
            end
            if (errs > 10) break;
        end
        reset = 0; in_valid = 0; wb_w = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard_bypass();
        test_backpressure();
        test_set_clear_same_cycle();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 5, register address width.
REQ-002 SHALL have parameter WORD_SIZE, default 32, register data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  this stage accepts the instruction this cycle.
REQ-007 SHALL have ports in_rs1, in_rs2, in_rd  input  ADDR_SIZE  source and destination register addresses.
REQ-008 SHALL have port in_rd_en  input  1  instruction writes in_rd.
REQ-009 SHALL have ports rf_rad1, rf_rad2  output  ADDR_SIZE  register bank read addresses, combinationally equal to in_rs1, in_rs2.
REQ-010 SHALL have ports rf_rdat1, rf_rdat2  input  WORD_SIZE  register bank combinational read data.
REQ-011 SHALL have ports wb_w (1), wb_wad (ADDR_SIZE), wb_wdat (WORD_SIZE)  input  snooped copy of the bank write port.
REQ-012 SHALL have port out_valid  output  1  operand packet valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts packet.
REQ-014 SHALL have ports out_op1, out_op2 (WORD_SIZE), out_rd (ADDR_SIZE), out_rd_en (1)  output  registered packet.
REQ-015 SHALL have port stall_cnt  output  16  count of cycles stalled on hazard.

Function
REQ-016 SHALL keep a busy bit per register (2**ADDR_SIZE bits) marking destinations issued but not yet written back.
REQ-017 SHALL keep a one-entry output slot with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 SHALL define hazard = (busy[in_rs1] or busy[in_rs2] or (in_rd_en and busy[in_rd])), where a busy bit being cleared by wb_w in the same cycle counts as not busy.
REQ-019 SHALL drive in_ready = !hazard and (slot EMPTY or out_ready), combinationally.
REQ-020 SHALL accept on in_valid and in_ready; packet appears on outputs the next cycle (latency 1).
REQ-021 SHALL bypass: out_op1 loads wb_wdat if wb_w and wb_wad==in_rs1 at accept, else rf_rdat1; same for out_op2/in_rs2.
REQ-022 SHALL set busy[in_rd] on accept when in_rd_en; SHALL clear busy[wb_wad] on wb_w.
REQ-023 SHALL, when set and clear target the same address in the same cycle, leave the bit set.
REQ-024 Slot transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL (new packet) on out_ready with accept; FULL holds packet unchanged while out_ready=0.
REQ-025 SHALL increment stall_cnt by 1 each cycle in_valid=1 and hazard=1, saturating at 16'hFFFF.

Reset
REQ-026 SHALL, on reset, clear all busy bits, set slot EMPTY, zero out_op1, out_op2, out_rd, out_rd_en, stall_cnt.
REQ-027 SHALL, on reset mid-operation, discard any held packet; reset has priority over accept and writeback.
REQ-028 SHALL drive in_ready=0 while reset is asserted.

Configuration
REQ-029 With REG0_ZERO_EN defined, register 0 SHALL read as zero (no bypass), never become busy, and never cause hazard.
REQ-030 Without REG0_ZERO_EN, register 0 SHALL behave as every other register.

Verification
REQ-031 Reset then in_rs1=3,in_rs2=4,rdat1=0x11,rdat2=0x22,rd=5 -> next cycle out_valid=1, op1=0x11, op2=0x22, busy[5]=1.
REQ-032 Busy[5]=1, issue rs1=5 -> in_ready=0, stall_cnt increments each cycle; wb_w=1,wad=5,wdat=0xABCD -> accepted that cycle, op1=0xABCD.
REQ-033 out_ready=0 with slot FULL for 3 cycles -> outputs stable, in_ready=0; out_ready=1 with in_valid=1 -> back-to-back packets, no bubble.
REQ-034 Accept rd=7 while wb_w=1,wad=7 same cycle -> busy[7]=1 afterwards.
REQ-035 REG0_ZERO_EN defined, rs1=0,rd=0,rd_en=1, wb_w=1,wad=0,wdat=0x5 -> op1=0, busy[0]=0; undefined -> op1=0x5, busy[0]=1.
REQ-036 Reset asserted with slot FULL and busy bits set -> next cycle out_valid=0, all busy clear, stall_cnt=0.
